// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Summary  : Shared Qm.n format helpers and divider state encoding.
// Revision : 1.0  initial release
// ============================================================================
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fp_state_e;

    function automatic int fp_width(input int int_bits, input int frac_bits);
        return int_bits + frac_bits;
    endfunction

    // Quotient bits needed to keep FRACTION bits of precision after the point.
    function automatic int fp_iter(input int int_bits, input int frac_bits);
        return int_bits + 2 * frac_bits;
    endfunction

    function automatic longint fp_max_val(input bit is_signed, input int w);
        return is_signed ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
    endfunction

    function automatic longint fp_min_val(input bit is_signed, input int w);
        return is_signed ? -(longint'(1) << (w - 1)) : longint'(0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_div_step.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_step
// Summary  : One restoring-division iteration: shift, compare, subtract.
// Revision : 1.0  initial release
// ============================================================================
module fp_div_step #(
    parameter int W = 16
) (
    input  logic [W:0]   rem_in,
    input  logic [W-1:0] divisor,
    input  logic         bit_in,
    output logic [W:0]   rem_out,
    output logic         q_bit
);

    logic [W+1:0] w_shift;

    assign w_shift = {rem_in, bit_in};
    assign q_bit   = (w_shift >= {2'b00, divisor});
    // Remainder stays below the divisor, so the shifted value never needs bit W+1 after a subtract.
    assign rem_out = q_bit ? (w_shift[W:0] - {1'b0, divisor}) : w_shift[W:0];

endmodule
`default_nettype wire

// File: rtl/fp_divider.sv
`default_nettype none
// ============================================================================
// Module   : fp_divider
// Summary  : Iterative restoring fixed-point divider, one quotient bit/clock.
// Revision : 1.0  initial release
// ============================================================================
module fp_divider
    import fp_pkg::*;
#(
    parameter bit  SIGNED   = 1'b1,
    parameter int  INTEGER  = 2,
    parameter int  FRACTION = 14,
    localparam int W        = fp_width(INTEGER, FRACTION),
    localparam int ITER     = fp_iter(INTEGER, FRACTION)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         sat,
    output logic         div_zero
);

    localparam int               c_CW      = $clog2(ITER);
    localparam logic [W-1:0]     c_MAX     = W'(fp_max_val(SIGNED, W));
    localparam logic [W-1:0]     c_MIN     = W'(fp_min_val(SIGNED, W));
    localparam logic [ITER-1:0]  c_POS_LIM = ITER'(fp_max_val(SIGNED, W));
    localparam logic [ITER-1:0]  c_NEG_LIM = ITER'(-fp_min_val(SIGNED, W));

    fp_state_e          r_state, w_next;
    logic               r_sign;
    logic [W-1:0]       r_divisor;
    logic [ITER-1:0]    r_dividend;
    logic [W:0]         r_rem;
    logic [ITER-1:0]    r_quot;
    logic [c_CW-1:0]    r_count;
    logic [W-1:0]       r_out;
    logic               r_sat;
    logic               r_dz;

    logic               w_xfer;
    logic               w_a_neg, w_b_neg;
    logic [W-1:0]       w_a_mag, w_b_mag;
    logic [W:0]         w_rem_next;
    logic               w_qbit;
    logic [ITER-1:0]    w_quot_next;
    logic [W-1:0]       w_res_out;
    logic               w_res_sat;

    assign w_xfer  = in_valid & in_ready;
    assign w_a_neg = SIGNED & a[W-1];
    assign w_b_neg = SIGNED & b[W-1];
    // Most-negative input maps to itself, which is the correct unsigned magnitude.
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    fp_div_step #(
        .W (W)
    ) u_step (
        .rem_in  (r_rem),
        .divisor (r_divisor),
        .bit_in  (r_dividend[ITER-1]),
        .rem_out (w_rem_next),
        .q_bit   (w_qbit)
    );

    assign w_quot_next = {r_quot[ITER-2:0], w_qbit};

    always_comb begin
        w_res_out = w_quot_next[W-1:0];
        w_res_sat = 1'b0;
        if (SIGNED) begin
            if (!r_sign) begin
                if (w_quot_next > c_POS_LIM) begin
                    w_res_out = c_MAX;
                    w_res_sat = 1'b1;
                end
            end else if (w_quot_next > c_NEG_LIM) begin
                w_res_out = c_MIN;
                w_res_sat = 1'b1;
            end else begin
                w_res_out = -w_quot_next[W-1:0];
            end
        end else if (w_quot_next > c_POS_LIM) begin
            w_res_out = c_MAX;
            w_res_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = (b == '0) ? DONE : CALC;
            end
            CALC: begin
                if (r_count == '0) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign     <= 1'b0;
            r_divisor  <= '0;
            r_dividend <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_count    <= '0;
            r_out      <= '0;
            r_sat      <= 1'b0;
            r_dz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_sign     <= SIGNED & (a[W-1] ^ b[W-1]);
                        r_divisor  <= w_b_mag;
                        r_dividend <= {w_a_mag, {FRACTION{1'b0}}};
                        r_rem      <= '0;
                        r_quot     <= '0;
                        r_count    <= c_CW'(ITER - 1);
                        if (b == '0) begin
                            r_out <= w_a_neg ? c_MIN : c_MAX;
                            r_sat <= 1'b1;
                            r_dz  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_rem      <= w_rem_next;
                    r_quot     <= w_quot_next;
                    r_dividend <= {r_dividend[ITER-2:0], 1'b0};
                    r_count    <= r_count - 1'b1;
                    if (r_count == '0) begin
                        r_out <= w_res_out;
                        r_sat <= w_res_sat;
                        r_dz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out      = r_out;
    assign sat      = r_sat;
    assign div_zero = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_fp_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_divider
// Summary  : Self-checking bench for fp_divider (Q2.14 signed defaults).
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a, b;
    logic        in_valid, in_ready;
    logic [15:0] out;
    logic        out_valid, out_ready;
    logic        sat, div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    fp_divider dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat       (sat),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Reference: exact rational division of the Q2.14 values, truncated toward zero.
    function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                  output logic [15:0] eo, output logic es, output logic ed);
        longint ai, bi, an, bn, q;
        logic   neg;
        ai = longint'($signed(ma));
        bi = longint'($signed(mb));
        if (bi == 0) begin
            ed = 1'b1;
            es = 1'b1;
            eo = (ai < 0) ? 16'h8000 : 16'h7FFF;
            return;
        end
        ed  = 1'b0;
        an  = (ai < 0) ? -ai : ai;
        bn  = (bi < 0) ? -bi : bi;
        q   = (an * 16384) / bn;
        neg = (ai < 0) != (bi < 0);
        if (!neg) begin
            if (q > 32767) begin eo = 16'h7FFF; es = 1'b1; end
            else           begin eo = 16'(q);   es = 1'b0; end
        end else begin
            if (q > 32768) begin eo = 16'h8000; es = 1'b1; end
            else           begin eo = 16'(-q);  es = 1'b0; end
        end
    endfunction

    // Latency counts rising edges from the transfer edge (as 1) to the edge raising out_valid.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          output logic [15:0] ro, output logic rs, output logic rd,
                          output int lat);
        int guard;
        @(negedge clk);
        a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ro = out; rs = sat; rd = div_zero;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (out !== 16'h0000) begin n_fail++; $display("FAIL reset_out: got %h expected 0000", out); end
        n_checks++;
        if ({sat, div_zero} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {sat, div_zero}); end
    endtask

    task automatic test_directed();
        logic [15:0] va[5], vb[5], vo[5];
        logic        vs[5];
        logic [15:0] ro;
        logic        rs, rd;
        int          lat;
        va = '{16'h2000, 16'h1000, 16'hF000, 16'h4000, 16'hC000};
        vb = '{16'h4000, 16'h3000, 16'h3000, 16'h2000, 16'h2000};
        vo = '{16'h2000, 16'h1555, 16'hEAAB, 16'h7FFF, 16'h8000};
        vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], ro, rs, rd, lat);
            n_checks++;
            if (ro !== vo[i]) begin n_fail++; $display("FAIL directed_out[%0d]: got %h expected %h", i, ro, vo[i]); end
            n_checks++;
            if (rs !== vs[i]) begin n_fail++; $display("FAIL directed_sat[%0d]: got %b expected %b", i, rs, vs[i]); end
            n_checks++;
            if (rd !== 1'b0) begin n_fail++; $display("FAIL directed_dz[%0d]: got %b expected 0", i, rd); end
            n_checks++;
            if (lat != 31) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected 31", i, lat); end
        end
    endtask

    task automatic test_div_zero();
        logic [15:0] va[3], vo[3];
        logic [15:0] ro;
        logic        rs, rd;
        int          lat;
        va = '{16'h4000, 16'hC000, 16'h0000};
        vo = '{16'h7FFF, 16'h8000, 16'h7FFF};
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], 16'h0000, ro, rs, rd, lat);
            n_checks++;
            if (ro !== vo[i]) begin n_fail++; $display("FAIL dz_out[%0d]: got %h expected %h", i, ro, vo[i]); end
            n_checks++;
            if ({rs, rd} !== 2'b11) begin n_fail++; $display("FAIL dz_flags[%0d]: got %b expected 11", i, {rs, rd}); end
            n_checks++;
            if (lat != 1) begin n_fail++; $display("FAIL dz_latency[%0d]: got %0d expected 1", i, lat); end
        end
    endtask

    task automatic test_random();
        logic [15:0] ta, tbv, eo, ro;
        logic        es, ed, rs, rd;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            ta  = 16'($urandom);
            tbv = (i % 4 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            if (i % 7 == 3) tbv = {tbv[15], 15'h0};
            model(ta, tbv, eo, es, ed);
            run_op(ta, tbv, ro, rs, rd, lat);
            n_checks++;
            if ({ro, rs, rd} !== {eo, es, ed} || lat != (ed ? 1 : 31)) begin
                n_fail++;
                $display("FAIL random[%0d] a=%h b=%h: got out=%h sat=%b dz=%b lat=%0d expected out=%h sat=%b dz=%b",
                         i, ta, tbv, ro, rs, rd, lat, eo, es, ed);
            end
        end
    endtask

    task automatic test_back_to_back();
        int  lat;
        logic stable_ok;
        @(negedge clk);
        a = 16'h1000; b = 16'h3000; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        a = 16'h2000; b = 16'h4000;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        n_checks++;
        if (lat != 31) begin n_fail++; $display("FAIL bp_first_latency: got %0d expected 31", lat); end
        stable_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out !== 16'h1555 || out_valid !== 1'b1 || in_ready !== 1'b0) stable_ok = 1'b0;
        end
        n_checks++;
        if (!stable_ok) begin n_fail++; $display("FAIL bp_hold: got out=%h valid=%b in_ready=%b expected 1555/1/0", out, out_valid, in_ready); end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_handshake: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        n_checks++;
        if (out !== 16'h2000 || lat != 31) begin n_fail++; $display("FAIL bp_second: got out=%h lat=%0d expected 2000 lat=31", out, lat); end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        logic        seen;
        logic [15:0] ro;
        logic        rs, rd;
        int          lat;
        @(negedge clk);
        a = 16'h2000; b = 16'h3000; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_state: got valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_spurious: got out_valid=1 expected 0"); end
        out_ready = 1'b0;
        run_op(16'h4000, 16'h4000, ro, rs, rd, lat);
        n_checks++;
        if (ro !== 16'h4000 || rs !== 1'b0 || lat != 31) begin n_fail++; $display("FAIL midreset_next: got out=%h sat=%b lat=%0d expected 4000/0/31", ro, rs, lat); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b0;
        #23;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_directed();
        test_div_zero();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
